// File: rtl/luhn_check_gen.sv
// Luhn check-digit generator: collects the payload digits, computes the check digit,
// then replays payload and check digit to a downstream consumer.
module luhn_check_gen #(
  parameter int NUM_DIGITS = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_digit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] check_digit,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int NPAY = NUM_DIGITS - 1;
  localparam logic [IW-1:0] LAST_PAY = IW'(NUM_DIGITS - 2);
  localparam logic [IW-1:0] LAST_OUT = IW'(NUM_DIGITS - 1);
  // The payload digit next to the check digit is doubled, so parity of the payload length decides the first one.
  localparam logic DBL_INIT = 1'(NPAY % 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CALC    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  function automatic logic [3:0] luhn_contrib(input logic [3:0] d, input logic dbl);
    logic [4:0] d2;
    d2 = {d, 1'b0};
    if (!dbl) begin
      return d;
    end else if (d2 > 5'd9) begin
      return 4'(d2 - 5'd9);
    end else begin
      return d2[3:0];
    end
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] s, input logic [3:0] c);
    logic [4:0] t;
    t = {1'b0, s} + {1'b0, c};
    if (t >= 5'd10) begin
      return 4'(t - 5'd10);
    end else begin
      return t[3:0];
    end
  endfunction

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_sum;
  logic          r_dbl;
  logic [3:0]    r_buf [0:NPAY-1];
  logic [3:0]    r_check;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [3:0]    r_out_digit;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [3:0]    w_sum_next;
  logic [IW-1:0] w_next_idx;
  logic [3:0]    w_next_digit;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_sum_next = add_mod10(r_sum, luhn_contrib(in_digit, r_dbl));
  assign w_next_idx = r_idx + IW'(1);

  // Digit to present after the current output transfer: buffered payload or the check digit.
  always_comb begin
    w_next_digit = r_check;
    if (w_next_idx < LAST_OUT) begin
      w_next_digit = r_buf[w_next_idx];
    end else begin
      w_next_digit = r_check;
    end
  end

  // Payload store; contents are don't-care after reset.
  always_ff @(posedge CLOCK_50) begin
    if (r_state == S_COLLECT && w_in_xfer) begin
      r_buf[r_idx] <= in_digit;
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_sum       <= 4'd0;
      r_dbl       <= 1'b0;
      r_check     <= 4'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_digit <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_sum      <= 4'd0;
            r_dbl      <= DBL_INIT;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_in_xfer) begin
            r_sum <= w_sum_next;
            r_dbl <= ~r_dbl;
            r_idx <= w_next_idx;
            // A non-BCD digit aborts the generation; nothing is emitted.
            if (in_digit > 4'd9) begin
              r_error    <= 1'b1;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_idx == LAST_PAY) begin
              r_in_ready <= 1'b0;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_check     <= (r_sum == 4'd0) ? 4'd0 : 4'd10 - r_sum;
          r_idx       <= '0;
          r_out_digit <= r_buf[0];
          r_out_valid <= 1'b1;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (w_out_xfer) begin
            r_idx <= w_next_idx;
            if (r_idx == LAST_OUT) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_out_digit <= w_next_digit;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_digit   = r_out_digit;
  assign check_digit = r_check;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule
